// File: rtl/pkt_data_src_mux.sv
// pkt_data_src_mux
//   Registered source selector in front of the packetiser lanes. Each lane
//   carries one of three sources: packet-generator data, full-width ADC data
//   or reduced-width ADC data. A source change waits for a frame boundary.
//   The output then blanks for BLANK_CYC cycles, so no packet mixes two
//   sources. A per-lane mask zeroes individual lanes immediately.
//
// Ports
//   clk                in   capture clock
//   rst_n              in   asynchronous active-low reset
//   rf_self_test_mode  in   1: packet-generator source (wins over rf_96path_en)
//   rf_96path_en       in   1: full ADC source, 0: reduced ADC source
//   rf_lane_mask       in   per-lane enable, 0 forces the lane to zero
//   frame_sof          in   one-cycle frame boundary pulse
//   adc_full_data      in   full ADC lanes, lane i at [i*DATA_W +: DATA_W]
//   adc_half_data      in   reduced ADC lanes (HALF_LANES of them)
//   pkt_gen_data       in   packet-generator lanes
//   adc_data           out  selected, masked lanes (one register stage)
//   adc_data_vld       out  adc_data carries live data
//   src_active         out  active source: 0 GEN, 1 FULL, 2 HALF
//   switch_busy        out  a source switch is pending or blanking
module pkt_data_src_mux #(
  parameter int DATA_W     = 36,
  parameter int LANES      = 24,
  parameter int HALF_LANES = 12,
  parameter int BLANK_CYC  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rf_self_test_mode,
  input  logic                       rf_96path_en,
  input  logic [LANES-1:0]           rf_lane_mask,
  input  logic                       frame_sof,
  input  logic [LANES*DATA_W-1:0]    adc_full_data,
  input  logic [HALF_LANES*DATA_W-1:0] adc_half_data,
  input  logic [LANES*DATA_W-1:0]    pkt_gen_data,
  output logic [LANES*DATA_W-1:0]    adc_data,
  output logic                       adc_data_vld,
  output logic [1:0]                 src_active,
  output logic                       switch_busy
);

  localparam int CNT_W = $clog2(BLANK_CYC + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

  localparam logic [1:0] SRC_GEN  = 2'd0;
  localparam logic [1:0] SRC_FULL = 2'd1;
  localparam logic [1:0] SRC_HALF = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_BLANK    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [1:0]        src_active_q, src_active_d;
  logic [1:0]        req_src;

  logic [LANES*DATA_W-1:0] data_nxt;
  logic [LANES*DATA_W-1:0] adc_data_p0;
  logic                    vld_p0;

  assign req_src = rf_self_test_mode ? SRC_GEN :
                   rf_96path_en      ? SRC_FULL : SRC_HALF;

  // Switch control. The old source keeps flowing while a switch waits for
  // a frame boundary. The new source is latched only when the blank ends,
  // so a request change during the blank is picked up without a new wait.
  always_comb begin
    state_d      = state_q;
    blank_cnt_d  = blank_cnt_q;
    src_active_d = src_active_q;
    case (state_q)
      ST_RUN: begin
        if (req_src != src_active_q) begin
          if (frame_sof) begin
            state_d     = ST_BLANK;
            blank_cnt_d = BLANK_LOAD;
          end else begin
            state_d = ST_WAIT_SOF;
          end
        end
      end
      ST_WAIT_SOF: begin
        if (req_src == src_active_q) begin
          state_d = ST_RUN;
        end else if (frame_sof) begin
          state_d     = ST_BLANK;
          blank_cnt_d = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == '0) begin
          src_active_d = req_src;
          state_d      = ST_RUN;
        end else begin
          blank_cnt_d = blank_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = ST_BLANK;
        blank_cnt_d = BLANK_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      blank_cnt_q  <= BLANK_LOAD;
      src_active_q <= SRC_GEN;
    end else begin
      state_q      <= state_d;
      blank_cnt_q  <= blank_cnt_d;
      src_active_q <= src_active_d;
    end
  end

  // Lane selection. Reduced mode carries HALF_LANES lanes; the upper lanes
  // read zero.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] half_word;
    logic [DATA_W-1:0] src_word;

    if (g < HALF_LANES) begin : g_half
      assign half_word = adc_half_data[g*DATA_W +: DATA_W];
    end else begin : g_nohalf
      assign half_word = '0;
    end

    always_comb begin
      case (src_active_q)
        SRC_GEN:  src_word = pkt_gen_data[g*DATA_W +: DATA_W];
        SRC_FULL: src_word = adc_full_data[g*DATA_W +: DATA_W];
        SRC_HALF: src_word = half_word;
        default:  src_word = '0;
      endcase
    end

    assign data_nxt[g*DATA_W +: DATA_W] =
      ((state_q == ST_BLANK) || !rf_lane_mask[g]) ? '0 : src_word;
  end

  // p0: output register, valid travels with data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_data_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      adc_data_p0 <= data_nxt;
      vld_p0      <= (state_q != ST_BLANK);
    end
  end

  assign adc_data     = adc_data_p0;
  assign adc_data_vld = vld_p0;
  assign src_active   = src_active_q;
  assign switch_busy  = (state_q != ST_RUN);

endmodule

// File: tb/tb_pkt_data_src_mux.sv
// Bench for pkt_data_src_mux: a table of per-cycle input records with
// hand-derived expected outputs, plus asynchronous reset sequences.
// Lane words are tagged {source tag, row stamp, lane index}. The expected
// data therefore shows which source fed the lane and from which cycle.
module tb_pkt_data_src_mux;

  localparam int DATA_W = 36;
  localparam int LANES  = 24;
  localparam int HALF   = 12;
  localparam int BW     = LANES * DATA_W;

  localparam logic [1:0] KZ = 2'd0;  // all lanes zero
  localparam logic [1:0] KF = 2'd1;  // full ADC
  localparam logic [1:0] KH = 2'd2;  // reduced ADC
  localparam logic [1:0] KG = 2'd3;  // packet generator

  localparam logic [LANES-1:0] M = 24'hFFFFFF;

  typedef struct {
    logic             pre_rst;
    logic             st;
    logic             p96;
    logic [LANES-1:0] mask;
    logic             sof;
    logic             vld;
    logic [1:0]       kind;
    logic [1:0]       src;
    logic             busy;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     rf_self_test_mode;
  logic                     rf_96path_en;
  logic [LANES-1:0]         rf_lane_mask;
  logic                     frame_sof;
  logic [BW-1:0]            adc_full_data;
  logic [HALF*DATA_W-1:0]   adc_half_data;
  logic [BW-1:0]            pkt_gen_data;
  logic [BW-1:0]            adc_data;
  logic                     adc_data_vld;
  logic [1:0]               src_active;
  logic                     switch_busy;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  pkt_data_src_mux #(
    .DATA_W(DATA_W), .LANES(LANES), .HALF_LANES(HALF), .BLANK_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rf_self_test_mode(rf_self_test_mode),
    .rf_96path_en(rf_96path_en),
    .rf_lane_mask(rf_lane_mask),
    .frame_sof(frame_sof),
    .adc_full_data(adc_full_data),
    .adc_half_data(adc_half_data),
    .pkt_gen_data(pkt_gen_data),
    .adc_data(adc_data),
    .adc_data_vld(adc_data_vld),
    .src_active(src_active),
    .switch_busy(switch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] lane_word(input logic [3:0] tag,
                                                  input int stamp, input int lane);
    return {tag, 16'(stamp), 16'(lane)};
  endfunction

  function automatic logic [BW-1:0] exp_data(input logic [1:0] kind,
                                             input logic [LANES-1:0] mask,
                                             input int stamp);
    logic [BW-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        case (kind)
          KF: d[i*DATA_W +: DATA_W] = lane_word(4'h1, stamp, i);
          KH: if (i < HALF) d[i*DATA_W +: DATA_W] = lane_word(4'h2, stamp, i);
          KG: d[i*DATA_W +: DATA_W] = lane_word(4'h3, stamp, i);
          default: ;
        endcase
      end
    end
    return d;
  endfunction

  task automatic add(input logic pre, input logic st, input logic p96,
                     input logic [LANES-1:0] mask, input logic sof,
                     input logic vld, input logic [1:0] kind,
                     input logic [1:0] src, input logic busy, input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.pre_rst = pre && (k == 0);
      v.st = st; v.p96 = p96; v.mask = mask; v.sof = sof;
      v.vld = vld; v.kind = kind; v.src = src; v.busy = busy;
      vecs.push_back(v);
    end
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL row%0d %s: got %0h expected %0h", row, name, got, exp);
    end
  endtask

  task automatic chk_data(input int row, input logic [BW-1:0] got,
                          input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL row%0d adc_data: got %h expected %h", row, got, exp);
    end
  endtask

  task automatic chk_reset_state(input int row);
    chk_data(row, adc_data, '0);
    chk("rst_vld", row, 32'(adc_data_vld), 32'd0);
    chk("rst_src", row, 32'(src_active), 32'd0);
    chk("rst_busy", row, 32'(switch_busy), 32'd1);
  endtask

  // Reset asserted mid-cycle, checked before any clock edge, released after
  // the next rising edge so the first table row owns the first blank cycle.
  task automatic reset_pulse(input int row);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state(row);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic step(input int r);
    vec_t v;
    v = vecs[r];
    if (v.pre_rst) reset_pulse(r);
    @(negedge clk);
    rf_self_test_mode = v.st;
    rf_96path_en      = v.p96;
    rf_lane_mask      = v.mask;
    frame_sof         = v.sof;
    for (int i = 0; i < LANES; i++) begin
      adc_full_data[i*DATA_W +: DATA_W] = lane_word(4'h1, r, i);
      pkt_gen_data[i*DATA_W +: DATA_W]  = lane_word(4'h3, r, i);
      if (i < HALF) adc_half_data[i*DATA_W +: DATA_W] = lane_word(4'h2, r, i);
    end
    @(posedge clk);
    #1;
    chk("vld", r, 32'(adc_data_vld), 32'(v.vld));
    chk("src_active", r, 32'(src_active), 32'(v.src));
    chk("switch_busy", r, 32'(switch_busy), 32'(v.busy));
    chk_data(r, adc_data, exp_data(v.kind, v.mask, r));
  endtask

  initial begin
    rst_n             = 1'b0;
    rf_self_test_mode = 1'b0;
    rf_96path_en      = 1'b1;
    rf_lane_mask      = M;
    frame_sof         = 1'b0;
    adc_full_data     = '0;
    adc_half_data     = '0;
    pkt_gen_data      = '0;

    // reset release into FULL: four blank cycles, then data
    add(0, 0, 1, M, 0,   0, KZ, 2'd0, 1, 3);
    add(0, 0, 1, M, 0,   0, KZ, 2'd1, 0, 1);
    add(0, 0, 1, M, 0,   1, KF, 2'd1, 0, 2);
    // FULL -> HALF request waits for sof, old data keeps flowing
    add(0, 0, 0, M, 0,   1, KF, 2'd1, 1, 20);
    add(0, 0, 0, M, 1,   1, KF, 2'd1, 1, 1);
    add(0, 0, 0, M, 0,   0, KZ, 2'd1, 1, 3);
    add(0, 0, 0, M, 0,   0, KZ, 2'd2, 0, 1);
    add(0, 0, 0, M, 0,   1, KH, 2'd2, 0, 2);
    // request withdrawn while waiting: no blank, vld stays high
    add(0, 0, 1, M, 0,   1, KH, 2'd2, 1, 2);
    add(0, 0, 0, M, 0,   1, KH, 2'd2, 0, 2);
    // sof and self-test together; a sof during the blank is ignored
    add(0, 1, 0, M, 1,   1, KH, 2'd2, 1, 1);
    add(0, 1, 0, M, 1,   0, KZ, 2'd2, 1, 1);
    add(0, 1, 0, M, 0,   0, KZ, 2'd2, 1, 2);
    add(0, 1, 0, M, 0,   0, KZ, 2'd0, 0, 1);
    add(0, 1, 0, M, 0,   1, KG, 2'd0, 0, 2);
    // lane 0 masked in RUN
    add(0, 1, 0, 24'hFFFFFE, 0, 1, KG, 2'd0, 0, 2);
    add(0, 1, 0, M, 0,   1, KG, 2'd0, 0, 1);
    // request moves from FULL to HALF inside the blank; exit picks HALF
    add(0, 0, 1, M, 1,   1, KG, 2'd0, 1, 1);
    add(0, 0, 1, M, 0,   0, KZ, 2'd0, 1, 2);
    add(0, 0, 0, M, 0,   0, KZ, 2'd0, 1, 1);
    add(0, 0, 0, M, 0,   0, KZ, 2'd2, 0, 1);
    add(0, 0, 0, M, 0,   1, KH, 2'd2, 0, 1);
    // reset during a blank restarts the full blank sequence
    add(0, 0, 1, M, 1,   1, KH, 2'd2, 1, 1);
    add(0, 0, 1, M, 0,   0, KZ, 2'd2, 1, 1);
    add(1, 0, 1, M, 0,   0, KZ, 2'd0, 1, 3);
    add(0, 0, 1, M, 0,   0, KZ, 2'd1, 0, 1);
    add(0, 0, 1, M, 0,   1, KF, 2'd1, 0, 2);

    repeat (3) @(posedge clk);
    #1 chk_reset_state(-1);
    #2 rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) step(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
